// File: rtl/uart_bridge.sv
// uart_bridge: byte-stream to UART bridge with TX/RX FIFOs, framing check and overrun detection.
module uart_bridge_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

module uart_bridge #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] TICK = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 2);
  localparam logic [2:0]  LAST = 3'(DATA_BITS - 1);
  state_t tx_state, tx_nxt, rx_state, rx_nxt;
  logic [15:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh, tx_dout, rx_dout;
  logic tx_full, tx_empty, tx_pop, tx_tick, rdy_en;
  logic rx_full, rx_empty, rx_pop, rx_wr, rx_tick, rx_half;
  logic [1:0] sync;
  logic rx_s, rx_prev, rx_brk, push_q, push_set, err_set;
  assign tx_ready = rdy_en && !tx_full;
  assign tx_tick  = tx_cnt == TICK;
  uart_bridge_fifo #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(tx_valid && tx_ready), .din(tx_data),
    .rd(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  always_comb begin
    tx_nxt = tx_state;
    tx_pop = 1'b0;
    case (tx_state)
      IDLE:  if (!tx_empty) {tx_nxt, tx_pop} = {START, 1'b1};
      START: if (tx_tick) tx_nxt = DATA;
      DATA:  if (tx_tick && tx_bit == LAST) tx_nxt = STOP;
      STOP:  if (tx_tick) {tx_nxt, tx_pop} = tx_empty ? {IDLE, 1'b0} : {START, 1'b1};
      default: tx_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      tx_state <= tx_nxt;
      tx_cnt   <= (tx_state == IDLE || tx_nxt != tx_state || tx_tick) ? '0 : tx_cnt + 1'b1;
      tx_bit   <= (tx_state != DATA) ? '0 : tx_bit + 3'(tx_tick);
      if (tx_pop) tx_sh <= tx_dout;
      else if (tx_state == DATA && tx_tick) tx_sh <= tx_sh >> 1;
      uart_tx  <= (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_sh[0] : 1'b1;
    end
  // Edge detect runs on the synchronised line; START samples mid-bit relative to it.
  assign rx_s     = sync[1];
  assign rx_tick  = rx_cnt == TICK;
  assign rx_half  = rx_cnt == HALF;
  assign push_set = rx_state == STOP && !rx_brk && rx_tick && rx_s;
  assign err_set  = rx_state == STOP && !rx_brk && rx_tick && !rx_s;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_wr    = push_q && (!rx_full || rx_pop);
  assign rx_overrun = push_q && rx_full && !rx_pop;
  assign rx_data  = rx_valid ? rx_dout : '0;
  uart_bridge_fifo #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(rx_wr), .din(rx_sh),
    .rd(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      IDLE:  if (rx_prev && !rx_s) rx_nxt = START;
      START: if (rx_half) rx_nxt = rx_s ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit == LAST) rx_nxt = STOP;
      STOP:  if (rx_brk ? rx_s : push_set) rx_nxt = IDLE;
      default: rx_nxt = IDLE;
    endcase
  end
  // After a bad stop bit the FSM parks in STOP until the line returns high.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync         <= 2'b11;
      rx_prev      <= 1'b1;
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_brk       <= 1'b0;
      push_q       <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], uart_rx};
      rx_prev      <= rx_s;
      rx_state     <= rx_nxt;
      rx_cnt       <= (rx_state == IDLE || rx_nxt != rx_state || rx_tick) ? '0 : rx_cnt + 1'b1;
      rx_bit       <= (rx_state != DATA) ? '0 : rx_bit + 3'(rx_tick);
      if (rx_state == DATA && rx_tick) rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
      rx_brk       <= err_set || (rx_brk && rx_nxt == STOP);
      push_q       <= push_set;
      rx_frame_err <= err_set;
    end
endmodule

// File: tb/tb_uart_bridge.sv
// tb_uart_bridge: directed table-driven checks of the UART bridge TX and RX paths.
module tb_uart_bridge;
  localparam int DIV = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = '0, rx_data;
  logic tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic uart_rx = 1'b1, uart_tx, rx_frame_err, rx_overrun;
  int tests = 0, fails = 0, err_cnt = 0, ov_cnt = 0;
  typedef struct {logic [7:0] b; logic stop; logic v; int e;} rxv_t;
  rxv_t tbl [6];
  logic [7:0] q [$];
  always #5 clk = ~clk;
  uart_bridge dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );
  always @(posedge clk) begin
    if (rx_frame_err) err_cnt <= err_cnt + 1;
    if (rx_overrun) ov_cnt <= ov_cnt + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      uart_rx = f[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = f[9];
    repeat (DIV / 2) @(negedge clk);
  endtask
  task automatic send_full(input logic [7:0] b);
    send_frame(b, 1'b1);
    repeat (DIV / 2) @(negedge clk);
  endtask
  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  task automatic wait_low();
    int n;
    n = 0;
    while (uart_tx !== 1'b0 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("tx_start_timeout", n < 40, 1);
  endtask
  task automatic check_frame(input logic [7:0] b);
    logic [9:0] f;
    int bad;
    f = {1'b1, b, 1'b0};
    bad = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < DIV; j++) begin
        if (uart_tx !== f[i]) bad++;
        @(posedge clk);
        #1;
      end
    chk($sformatf("tx_frame_%02h_badsamples", b), bad, 0);
  endtask
  initial begin
    tbl[0] = '{8'h3C, 1'b1, 1'b1, 0};
    tbl[1] = '{8'h55, 1'b0, 1'b0, 1};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 0};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 0};
    tbl[5] = '{8'h81, 1'b1, 1'b1, 0};
    #12;
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_frame_err", rx_frame_err, 0);
    chk("rst_overrun", rx_overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", tx_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", tx_ready, 1);
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(posedge clk);
    #1 chk("a5_edge1_high", uart_tx, 1);
    @(posedge clk);
    #1 chk("a5_edge2_low", uart_tx, 0);
    check_frame(8'hA5);
    chk("a5_idle_after", uart_tx, 1);
    repeat (10) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tx_data = 8'(i + 1);
          tx_valid = 1'b1;
          chk($sformatf("burst_ready_%0d", i), tx_ready, 1);
          @(posedge clk);
          #1;
        end
        tx_valid = 1'b0;
        chk("burst_ready_drop", tx_ready, 0);
      end
      begin
        wait_low();
        for (int i = 1; i <= 5; i++) check_frame(8'(i));
        chk("burst_idle_after", uart_tx, 1);
      end
    join
    @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      int e0;
      e0 = err_cnt;
      send_frame(tbl[r].b, tbl[r].stop);
      repeat (3) @(negedge clk);
      chk($sformatf("rx%0d_valid", r), rx_valid, tbl[r].v);
      chk($sformatf("rx%0d_data", r), rx_data, tbl[r].v ? tbl[r].b : 8'h00);
      repeat (DIV / 2 - 3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (6) @(negedge clk);
      chk($sformatf("rx%0d_errs", r), err_cnt - e0, tbl[r].e);
      if (rx_valid) begin
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
      chk($sformatf("rx%0d_empty", r), rx_valid, 0);
    end
    begin
      int e0;
      e0 = err_cnt;
      uart_rx = 1'b0;
      repeat (6) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_valid", rx_valid, 0);
      chk("glitch_errs", err_cnt - e0, 0);
    end
    begin
      int o0;
      o0 = ov_cnt;
      for (int i = 0; i < 5; i++) send_full(8'h11 + 8'(i));
      repeat (4) @(negedge clk);
      chk("ovr_pulses", ov_cnt - o0, 1);
      chk("ovr_valid", rx_valid, 1);
      send_frame(8'h16, 1'b1);
      repeat (2) @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (DIV / 2) @(negedge clk);
      chk("full_pushpop_no_ovr", ov_cnt - o0, 1);
      q = '{8'h12, 8'h13, 8'h14, 8'h16};
      foreach (q[i]) pop_chk($sformatf("ovr_pop_%0d", i), q[i]);
      chk("ovr_drained", rx_valid, 0);
    end
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midframe_tx_low", uart_tx, 0);
    rst_n = 1'b0;
    #1 chk("midframe_rst_tx_high", uart_tx, 1);
    chk("midframe_rst_ready", tx_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rerst_ready", tx_ready, 1);
    repeat (30) @(posedge clk);
    #1 chk("rerst_tx_idle", uart_tx, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_bridge.md
UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 Parameter CLK_DIV, default 16: clk cycles per UART bit; legal range 4..65535; even values only.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 Parameter FIFO_DEPTH, default 4: entries per TX FIFO and per RX FIFO; power of 2, range 2..16.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 tx_data  in  DATA_BITS  byte to transmit.
REQ-007 tx_valid  in  1  tx_data is valid.
REQ-008 tx_ready  out  1  TX FIFO can accept a byte.
REQ-009 rx_data  out  DATA_BITS  head of RX FIFO.
REQ-010 rx_valid  out  1  RX FIFO not empty.
REQ-011 rx_ready  in  1  consumer takes rx_data.
REQ-012 uart_rx  in  1  serial input, asynchronous to clk, idle high.
REQ-013 uart_tx  out  1  serial output, idle high.
REQ-014 rx_frame_err  out  1  one-cycle pulse: bad stop bit.
REQ-015 rx_overrun  out  1  one-cycle pulse: received byte dropped because RX FIFO full.

Function
REQ-016 TX handshake: byte written to TX FIFO on an edge where tx_valid && tx_ready; tx_ready = !tx_fifo_full, independent of tx_valid.
REQ-017 TX FSM states IDLE, START, DATA, STOP; IDLE->START pops the FIFO when it is non-empty; START->DATA, DATA->STOP after DATA_BITS bits, STOP->IDLE, or STOP->START directly when the FIFO is non-empty.
REQ-018 Each TX bit is held on uart_tx for exactly CLK_DIV cycles; frame = start 0, data LSB first, one stop 1; no parity.
REQ-019 TX latency: when idle with an empty FIFO, uart_tx goes low on the 2nd rising edge after the accepting edge.
REQ-020 Back-to-back TX: no idle gap between the stop bit and the next start bit while the FIFO is non-empty.
REQ-021 uart_rx passes through a 2-flop synchroniser before any use.
REQ-022 RX FSM states IDLE, START, DATA, STOP; IDLE->START on a synchronised 1->0 transition.
REQ-023 RX start check: sample at CLK_DIV/2 cycles after the edge; if high, treat as a glitch and return to IDLE with no output.
REQ-024 RX data sampling: each data and stop bit sampled once, CLK_DIV cycles after the previous sample.
REQ-025 Stop sample 1: push byte to RX FIFO on the following edge.
REQ-026 Stop sample 0: pulse rx_frame_err, discard byte, return to IDLE only after uart_rx is sampled high (no false restart on a break).
REQ-027 RX FIFO full at push: byte discarded, rx_overrun pulses, FIFO contents unchanged.
REQ-028 RX pop on an edge where rx_valid && rx_ready; rx_data valid combinationally from FIFO head.
REQ-029 Simultaneous push and pop on either FIFO: both take effect; count unchanged.
REQ-030 RX FIFO full with a push and pop on the same edge: push accepted, no overrun.
REQ-031 Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty derived from the MSB comparison.
REQ-032 Bit-period counters are 16 bits and reload on every state transition.

Reset
REQ-033 While rst_n=0: uart_tx=1, tx_ready=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_data=0, both FSMs IDLE, both FIFOs empty, synchroniser flops=1.
REQ-034 Reset asserted mid-frame aborts the frame immediately; uart_tx=1 in the same cycle; partial RX byte discarded.
REQ-035 tx_ready rises on the first rising edge after rst_n deasserts.

Verification
REQ-036 Test CLK_DIV=16, DATA_BITS=8: write 0xA5 -> uart_tx low 2 edges later, then bits 0,1,0,1,0,0,1,0,1,1 for 16 cycles each (160 cycles total), then 1.
REQ-037 Test: write 0x01, 0x02, 0x03, 0x04, 0x05 with tx_valid held high -> tx_ready drops after 5 accepts (4 queued + 1 in flight); 5 frames sent with no idle gap.
REQ-038 Test: drive frame 0x3C on uart_rx at 16 cycles/bit -> rx_valid=1, rx_data=0x3C, within 3 cycles of the stop-bit midpoint.
REQ-039 Test: 6-cycle low pulse on idle uart_rx -> no rx_valid and no rx_frame_err.
REQ-040 Test: frame 0x55 with stop bit 0 -> one rx_frame_err pulse, rx_valid stays 0.
REQ-041 Test: 5 frames received with rx_ready=0 -> FIFO holds the first 4, one rx_overrun pulse; rst_n=0 mid-TX-frame -> uart_tx=1 at once.
